// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-bank op encodings and cell control payload.
package cpu_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_NOP  = 2'b00;
  localparam logic [OP_W-1:0] OP_LOAD = 2'b01;
  localparam logic [OP_W-1:0] OP_INC  = 2'b10;
  localparam logic [OP_W-1:0] OP_DEC  = 2'b11;

  // One-hot write controls for a single register cell.
  typedef struct packed {
    logic load;
    logic inc;
    logic dec;
  } cell_ctrl_t;

  localparam cell_ctrl_t CELL_IDLE = '{load: 1'b0, inc: 1'b0, dec: 1'b0};

  // Decode an op code into cell controls.
  function automatic cell_ctrl_t decode_op(input logic [OP_W-1:0] op);
    cell_ctrl_t c;
    c = CELL_IDLE;
    case (op)
      OP_LOAD: c.load = 1'b1;
      OP_INC:  c.inc  = 1'b1;
      OP_DEC:  c.dec  = 1'b1;
      default: c = CELL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/register_bank_buffered_cell.sv
// Single WIDTH-bit register with load/inc/dec, sync reset and wrap detection.
module register_cell
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_reset,
  input  cell_ctrl_t       i_ctrl,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_value,
  output logic             o_wrap_det_c
);

  logic [WIDTH-1:0] r_value;

  // Value register; controls are one-hot so priority order is immaterial.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_value <= '0;
    end else if (i_ctrl.load) begin
      r_value <= i_data;
    end else if (i_ctrl.inc) begin
      r_value <= r_value + WIDTH'(1);
    end else if (i_ctrl.dec) begin
      r_value <= r_value - WIDTH'(1);
    end
  end

  // Wrap occurs when this edge's inc/dec crosses the all-ones/zero boundary.
  always_comb begin
    o_wrap_det_c = (i_ctrl.inc && (&r_value)) || (i_ctrl.dec && (r_value == '0));
  end

  assign o_value = r_value;

endmodule

// File: rtl/register_bank_buffered.sv
// Register bank with a combinational read port, a tristate bus port and a wrap pulse.
module register_bank_buffered
  import cpu_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned NUM_REGS = 4,
  localparam int unsigned SEL_W    = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [SEL_W-1:0] wsel,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0] asel,
  output logic [WIDTH-1:0] a_out,
  input  logic [SEL_W-1:0] bsel,
  input  logic             bus_enable,
  output logic [WIDTH-1:0] bus_out,
  output logic             wrap,
  output logic             a_zero
);

  logic [WIDTH-1:0] w_q [NUM_REGS];
  logic [NUM_REGS-1:0] w_wrap_det;
  logic             w_wsel_ok;
  cell_ctrl_t       w_op_ctrl;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             r_wrap;

  // Out-of-range write selects degrade every op to a NOP.
  always_comb begin
    w_wsel_ok = (32'(wsel) < NUM_REGS);
    w_op_ctrl = decode_op(op);
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    cell_ctrl_t w_ctrl;

    // Only the addressed cell sees the op; reset overrides in the cell.
    always_comb begin
      w_ctrl = CELL_IDLE;
      if (w_wsel_ok && (wsel == SEL_W'(g))) begin
        w_ctrl = w_op_ctrl;
      end
    end

    register_cell #(.WIDTH(WIDTH)) u_cell (
      .clk          (clk),
      .i_reset      (reset),
      .i_ctrl       (w_ctrl),
      .i_data       (data_in),
      .o_value      (w_q[g]),
      .o_wrap_det_c (w_wrap_det[g])
    );
  end

  // Read muxes from current state; unmatched selects read as zero.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (asel == SEL_W'(i)) w_a = w_q[i];
      if (bsel == SEL_W'(i)) w_b = w_q[i];
    end
  end

  // Wrap pulse, one cycle after the wrapping edge; cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= |w_wrap_det;
    end
  end

  assign a_out   = w_a;
  assign a_zero  = (w_a == '0);
  assign bus_out = bus_enable ? w_b : {WIDTH{1'bz}};
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_register_bank_buffered.sv
// Directed self-checking bench for register_bank_buffered.
`timescale 1ns/1ps
module tb_register_bank_buffered;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;

  // Main DUT: WIDTH=8, NUM_REGS=4
  logic [1:0] op;
  logic [1:0] wsel, asel, bsel;
  logic [7:0] data_in;
  logic       bus_enable;
  wire  [7:0] a_out, bus_out;
  wire        wrap, a_zero;

  // Small DUT: WIDTH=8, NUM_REGS=3 (SEL_W=2)
  logic [1:0] op3;
  logic [1:0] wsel3, asel3, bsel3;
  logic [7:0] data3;
  logic       bus_en3;
  wire  [7:0] a_out3, bus_out3;
  wire        wrap3, a_zero3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_bank_buffered #(.WIDTH(8), .NUM_REGS(4)) u_dut (
    .clk(clk), .reset(reset), .op(op), .wsel(wsel), .data_in(data_in),
    .asel(asel), .a_out(a_out), .bsel(bsel), .bus_enable(bus_enable),
    .bus_out(bus_out), .wrap(wrap), .a_zero(a_zero)
  );

  register_bank_buffered #(.WIDTH(8), .NUM_REGS(3)) u_dut3 (
    .clk(clk), .reset(reset), .op(op3), .wsel(wsel3), .data_in(data3),
    .asel(asel3), .a_out(a_out3), .bsel(bsel3), .bus_enable(bus_en3),
    .bus_out(bus_out3), .wrap(wrap3), .a_zero(a_zero3)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read register r of the main DUT through port A.
  task automatic read_a(input string tag, input logic [1:0] r, input logic [7:0] exp);
    asel = r;
    #1;
    check_vec(tag, {24'h0, a_out}, {24'h0, exp});
  endtask

  task automatic read_a3(input string tag, input logic [1:0] r, input logic [7:0] exp);
    asel3 = r;
    #1;
    check_vec(tag, {24'h0, a_out3}, {24'h0, exp});
  endtask

  // A disabled bus floats; a 2-state simulator may resolve the float to 0.
  function automatic logic floating(input logic [7:0] v);
    return (v === 8'hzz) || (v === 8'h00);
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [1:0] r, input logic [7:0] d);
    op = o; wsel = r; data_in = d;
    tick();
    op = OP_NOP;
  endtask

  initial begin
    reset = 1'b1;
    op = OP_NOP; wsel = '0; asel = '0; bsel = '0; data_in = '0; bus_enable = 1'b0;
    op3 = OP_NOP; wsel3 = '0; asel3 = '0; bsel3 = '0; data3 = '0; bus_en3 = 1'b0;
    #2;
    // Bus must float even while reset is held.
    check_vec("bus_z_in_reset", {31'h0, floating(bus_out)}, 32'd1);
    tick();
    reset = 1'b0;

    // Reset state.
    for (int i = 0; i < 4; i++) begin
      read_a("reset_reg", 2'(i), 8'h00);
      check_vec("reset_a_zero", {31'h0, a_zero}, 32'd1);
    end
    check_vec("reset_wrap", {31'h0, wrap}, 32'd0);
    check_vec("reset_bus_z", {31'h0, floating(bus_out)}, 32'd1);

    // LOAD and bus.
    do_op(OP_LOAD, 2'd2, 8'hA5);
    bsel = 2'd2; bus_enable = 1'b1; #1;
    check_vec("bus_a5", {24'h0, bus_out}, 32'h0000_00A5);
    bus_enable = 1'b0; #1;
    check_vec("bus_off_z", {31'h0, bus_out === 8'hzz || bus_out === 8'h00}, 32'd1);
    read_a("load_reg0", 2'd0, 8'h00);
    read_a("load_reg1", 2'd1, 8'h00);
    read_a("load_reg3", 2'd3, 8'h00);
    read_a("load_reg2", 2'd2, 8'hA5);
    check_vec("a_zero_nz", {31'h0, a_zero}, 32'd0);

    // Wrap behaviour on reg 1.
    do_op(OP_LOAD, 2'd1, 8'hFF);
    check_vec("wrap_after_load", {31'h0, wrap}, 32'd0);
    do_op(OP_INC, 2'd1, 8'h00);
    read_a("inc_wrap_val", 2'd1, 8'h00);
    check_vec("inc_wrap_pulse", {31'h0, wrap}, 32'd1);
    tick();
    check_vec("wrap_one_cycle", {31'h0, wrap}, 32'd0);
    do_op(OP_DEC, 2'd1, 8'h00);
    read_a("dec_wrap_val", 2'd1, 8'hFF);
    check_vec("dec_wrap_pulse", {31'h0, wrap}, 32'd1);
    // Back-to-back wrapping ops keep wrap high on consecutive cycles.
    op = OP_INC; wsel = 2'd1;
    tick();
    read_a("b2b_inc_val", 2'd1, 8'h00);
    check_vec("b2b_wrap1", {31'h0, wrap}, 32'd1);
    op = OP_DEC;
    tick();
    op = OP_NOP;
    read_a("b2b_dec_val", 2'd1, 8'hFF);
    check_vec("b2b_wrap2", {31'h0, wrap}, 32'd1);
    do_op(OP_LOAD, 2'd1, 8'h10);
    do_op(OP_INC, 2'd1, 8'h00);
    read_a("inc_nowrap_val", 2'd1, 8'h11);
    check_vec("inc_nowrap", {31'h0, wrap}, 32'd0);
    do_op(OP_DEC, 2'd1, 8'h00);
    read_a("dec_nowrap_val", 2'd1, 8'h10);

    // Read-during-write on reg 3.
    do_op(OP_LOAD, 2'd3, 8'h07);
    op = OP_LOAD; wsel = 2'd3; data_in = 8'h09; asel = 2'd3;
    #1;
    check_vec("rdw_before", {24'h0, a_out}, 32'h0000_0007);
    tick();
    op = OP_NOP;
    check_vec("rdw_after", {24'h0, a_out}, 32'h0000_0009);
    read_a("untouched_reg2", 2'd2, 8'hA5);
    read_a("untouched_reg1", 2'd1, 8'h10);

    // Reset mid-stream: INC reg 0 from 0xFE, reset on the third edge.
    do_op(OP_LOAD, 2'd0, 8'hFE);
    asel = 2'd0;
    op = OP_INC; wsel = 2'd0;
    tick();
    check_vec("ms_edge1", {24'h0, a_out}, 32'h0000_00FF);
    check_vec("ms_wrap1", {31'h0, wrap}, 32'd0);
    tick();
    check_vec("ms_edge2", {24'h0, a_out}, 32'h0000_0000);
    check_vec("ms_wrap2", {31'h0, wrap}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_vec("ms_reset_val", {24'h0, a_out}, 32'h0000_0000);
    check_vec("ms_reset_wrap", {31'h0, wrap}, 32'd0);
    tick();
    check_vec("ms_edge4", {24'h0, a_out}, 32'h0000_0001);
    check_vec("ms_wrap4", {31'h0, wrap}, 32'd0);
    tick();
    op = OP_NOP;
    check_vec("ms_edge5", {24'h0, a_out}, 32'h0000_0002);
    check_vec("ms_wrap5", {31'h0, wrap}, 32'd0);
    read_a("ms_reg2_cleared", 2'd2, 8'h00);
    read_a("ms_reg3_cleared", 2'd3, 8'h00);

    // Out-of-range selects on the three-register bank.
    op3 = OP_LOAD;
    wsel3 = 2'd0; data3 = 8'h11; tick();
    wsel3 = 2'd1; data3 = 8'h22; tick();
    wsel3 = 2'd2; data3 = 8'h33; tick();
    wsel3 = 2'd3; data3 = 8'h55; tick();
    op3 = OP_INC; tick();
    check_vec("oor_wrap", {31'h0, wrap3}, 32'd0);
    op3 = OP_NOP;
    read_a3("oor_reg0", 2'd0, 8'h11);
    read_a3("oor_reg1", 2'd1, 8'h22);
    read_a3("oor_reg2", 2'd2, 8'h33);
    read_a3("oor_read", 2'd3, 8'h00);
    check_vec("oor_a_zero", {31'h0, a_zero3}, 32'd1);
    bsel3 = 2'd3; bus_en3 = 1'b1; #1;
    check_vec("oor_bus", {24'h0, bus_out3}, 32'h0000_0000);
    bsel3 = 2'd2; #1;
    check_vec("bus3_reg2", {24'h0, bus_out3}, 32'h0000_0033);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/register_bank_buffered.md
REGISTER_BANK_BUFFERED -- requirements
Module: register_bank_buffered

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of every register in bits; legal range 2..32.
REQ-002 Parameter NUM_REGS, default 4, SHALL set the register count; legal range 2..16.
REQ-003 Derived constant SEL_W SHALL equal max(1, ceil(log2(NUM_REGS))).
REQ-004 Clocking SHALL be one clock, with a synchronous, active-high reset.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge only.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port op, input, 2 bits: operation code. 00 = NOP, 01 = LOAD, 10 = INC, 11 = DEC.
REQ-008 Port wsel, input, SEL_W bits: target register for op.
REQ-009 Port data_in, input, WIDTH bits: LOAD data.
REQ-010 Port asel, input, SEL_W bits: select for read port A.
REQ-011 Port a_out, output, WIDTH bits: read port A, always driven.
REQ-012 Port bsel, input, SEL_W bits: select for bus read port B.
REQ-013 Port bus_enable, input, 1 bit: drives port B onto the bus when high.
REQ-014 Port bus_out, output, WIDTH bits: tristate bus port B; all Z when bus_enable is low.
REQ-015 Port wrap, output, 1 bit: registered one-cycle pulse on INC/DEC overflow or underflow.
REQ-016 Port a_zero, output, 1 bit: high when a_out equals 0.

Function
REQ-017 LOAD SHALL write data_in into register[wsel] at the rising edge.
REQ-018 INC SHALL write register[wsel]+1 modulo 2^WIDTH; DEC SHALL write register[wsel]-1 modulo 2^WIDTH.
REQ-019 NOP SHALL leave all registers unchanged.
REQ-020 Registers other than wsel SHALL be unchanged in every cycle.
REQ-021 At most one register SHALL change per cycle.
REQ-022 A wsel value >= NUM_REGS SHALL turn any op into a NOP, and wrap SHALL stay 0.
REQ-023 a_out and bus_out SHALL be combinational from the current register state, with zero cycles of read latency.
REQ-024 Read-during-write SHALL return the pre-edge value; new data SHALL be visible only after the edge, with no bypass.
REQ-025 asel or bsel >= NUM_REGS SHALL read as all zeros; bus_out SHALL still honour bus_enable.
REQ-026 bus_out SHALL equal register[bsel] when bus_enable is 1.
REQ-027 bus_out SHALL be all Z when bus_enable is 0, including during reset.
REQ-028 wrap SHALL be 1 for exactly the cycle after an edge where INC took register all-ones to 0, or DEC took register 0 to all-ones; otherwise wrap SHALL be 0.
REQ-029 Back-to-back wrapping ops SHALL produce wrap high on consecutive cycles.
REQ-030 a_zero SHALL track a_out combinationally.

Reset
REQ-031 While reset is high at a rising edge, all registers SHALL be cleared to 0 and wrap to 0; op SHALL be ignored in that cycle.
REQ-032 Reset asserted mid-sequence, such as during INC streams, SHALL abort it; no wrap pulse SHALL follow the reset edge.
REQ-033 After reset, a_out SHALL be 0 and a_zero SHALL be 1; registers SHALL never hold X after the first reset edge.

Structure
REQ-034 The op encodings (OP_NOP, OP_LOAD, OP_INC, OP_DEC) SHALL live in the shared package cpu_pkg, for reuse by the control unit.
REQ-035 The block SHALL instantiate NUM_REGS copies of one sub-module, register_cell.
REQ-036 register_cell SHALL be a WIDTH-bit register with load, inc, dec, and sync reset, and SHALL output its value plus a wrap-detect bit.
REQ-037 Read multiplexing, tristate control, and the wrap flop SHALL sit in the top module.

Verification
REQ-038 Scenario, reset: assert reset 1 cycle, then read all registers via asel -> every value 0, a_zero=1, bus_out Z with bus_enable=0.
REQ-039 Scenario, LOAD and bus: LOAD 0xA5 to reg 2, then bsel=2, bus_enable=1 -> bus_out=0xA5; bus_enable=0 -> bus_out Z; reg 0/1/3 remain 0.
REQ-040 Scenario, wrap: LOAD 0xFF to reg 1, then INC reg 1 -> reg 1=0x00, wrap=1 for one cycle; DEC reg 1 -> 0xFF, wrap=1 next cycle; INC 0x10 -> 0x11, wrap=0.
REQ-041 Scenario, read-during-write: reg 3=0x07, LOAD 0x09 to reg 3 with asel=3 -> a_out=0x07 before the edge, 0x09 after.
REQ-042 Scenario, out of range (NUM_REGS=3, SEL_W=2): LOAD 0x55 with wsel=3 -> no register changes; asel=3 -> a_out=0.
REQ-043 Scenario, reset mid-stream: INC reg 0 five times from 0xFE with reset on the third edge -> reg 0=0 after reset, wrap never high after the reset edge, the counting then resumes from 0.
